// File: rtl/owt_rx_ctrl.sv
// OWT receive frame controller: steers the run-length detector's threshold window,
// assembles MSB-first frames and supervises inter-symbol timeout. Optional parity: OWT_PARITY_EN.
module owt_rx_ctrl #(
  parameter int   CNT_W    = 10,
  parameter int   DATA_W   = 8,
  parameter logic SYNC_VAL = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_smp_vld,
  input  logic              i_det_vld,
  input  logic              i_det_data,
  input  logic [CNT_W-1:0]  i_sync_dn_th,
  input  logic [CNT_W-1:0]  i_sync_up_th,
  input  logic [CNT_W-1:0]  i_bit_dn_th,
  input  logic [CNT_W-1:0]  i_bit_up_th,
  input  logic [CNT_W-1:0]  i_tmo_th,
  output logic [CNT_W-1:0]  o_dn_th,
  output logic [CNT_W-1:0]  o_up_th,
  output logic              o_frm_vld,
  output logic [DATA_W-1:0] o_frm_data,
  output logic              o_frm_err,
  output logic              o_busy
);

  localparam int              BC_W    = $clog2(DATA_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2
`ifdef OWT_PARITY_EN
    , S_PAR = 2'd3
`endif
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_shreg, w_shreg_nxt;
  logic [BC_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [CNT_W-1:0]    r_tmo_cnt, w_tmo_cnt_nxt;
  logic                r_frm_vld, w_frm_vld_nxt;
  logic                r_frm_err, w_frm_err_nxt;
  logic [DATA_W-1:0]   r_frm_data, w_frm_data_nxt;
  logic [CNT_W-1:0]    r_dn_th, r_up_th;
  logic                w_tmo_hit, w_tmo_inc, w_in_frame;
`ifdef OWT_PARITY_EN
  logic                r_par_err, w_par_err_nxt;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_frm_vld  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_frm_data <= '0;
`ifdef OWT_PARITY_EN
      r_par_err  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_frm_vld  <= w_frm_vld_nxt;
      r_frm_err  <= w_frm_err_nxt;
      r_frm_data <= w_frm_data_nxt;
`ifdef OWT_PARITY_EN
      r_par_err  <= w_par_err_nxt;
`endif
    end
  end

  // >= rather than == so a threshold lowered mid-frame still fires
  assign w_tmo_hit = (i_tmo_th != '0) && (r_tmo_cnt >= i_tmo_th);
  assign w_tmo_inc = i_smp_vld && !i_det_vld && (r_tmo_cnt != '1);

  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_frm_vld_nxt  = 1'b0;
    w_frm_err_nxt  = 1'b0;
    w_frm_data_nxt = r_frm_data;
`ifdef OWT_PARITY_EN
    w_par_err_nxt  = r_par_err;
`endif
    if (!i_en) begin
      w_state_nxt   = S_IDLE;
      w_bit_cnt_nxt = '0;
      w_tmo_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_det_vld && (i_det_data == SYNC_VAL)) begin
            w_state_nxt   = S_DATA;
            w_bit_cnt_nxt = '0;
            w_tmo_cnt_nxt = '0;
          end
        end
        S_DATA: begin
          if (i_det_vld) begin
            w_shreg_nxt   = {r_shreg[DATA_W-2:0], i_det_data};
            w_tmo_cnt_nxt = '0;
            if (r_bit_cnt == BC_LAST) begin
              w_bit_cnt_nxt = '0;
`ifdef OWT_PARITY_EN
              w_state_nxt   = S_PAR;
`else
              w_state_nxt   = S_DONE;
`endif
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
            end
          end else if (w_tmo_hit) begin
            w_state_nxt   = S_IDLE;
            w_frm_err_nxt = 1'b1;
            w_bit_cnt_nxt = '0;
            w_tmo_cnt_nxt = '0;
          end else if (w_tmo_inc) begin
            w_tmo_cnt_nxt = r_tmo_cnt + CNT_W'(1);
          end
        end
`ifdef OWT_PARITY_EN
        S_PAR: begin
          if (i_det_vld) begin
            w_par_err_nxt = (^r_shreg) ^ i_det_data;
            w_tmo_cnt_nxt = '0;
            w_state_nxt   = S_DONE;
          end else if (w_tmo_hit) begin
            w_state_nxt   = S_IDLE;
            w_frm_err_nxt = 1'b1;
            w_bit_cnt_nxt = '0;
            w_tmo_cnt_nxt = '0;
          end else if (w_tmo_inc) begin
            w_tmo_cnt_nxt = r_tmo_cnt + CNT_W'(1);
          end
        end
`endif
        S_DONE: begin
          // any symbol landing here is dropped; hunting restarts from IDLE
          w_frm_vld_nxt  = 1'b1;
          w_frm_data_nxt = r_shreg;
`ifdef OWT_PARITY_EN
          w_frm_err_nxt  = r_par_err;
`endif
          w_state_nxt    = S_IDLE;
          w_bit_cnt_nxt  = '0;
          w_tmo_cnt_nxt  = '0;
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_bit_cnt_nxt = '0;
          w_tmo_cnt_nxt = '0;
        end
      endcase
    end
  end

`ifdef OWT_PARITY_EN
  assign w_in_frame = (r_state == S_DATA) || (r_state == S_PAR);
`else
  assign w_in_frame = (r_state == S_DATA);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dn_th <= '0;
      r_up_th <= '0;
    end else if (w_in_frame) begin
      r_dn_th <= i_bit_dn_th;
      r_up_th <= i_bit_up_th;
    end else begin
      r_dn_th <= i_sync_dn_th;
      r_up_th <= i_sync_up_th;
    end
  end

  assign o_dn_th    = r_dn_th;
  assign o_up_th    = r_up_th;
  assign o_frm_vld  = r_frm_vld;
  assign o_frm_err  = r_frm_err;
  assign o_frm_data = r_frm_data;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: doc/owt_rx_ctrl.md
Name: owt_rx_ctrl

Overview:
- Frame controller that sequences one OWT-mode run-length detector on a one-wire receive path.
- Drives the detector's down/up thresholds per frame phase: sync window while hunting, bit window while receiving.
- Assembles detected symbols into DATA_W-bit frames and supervises inter-symbol timeout.
- Sits between the detector and the register/command layer that consumes received words.

Parameters:
- CNT_W, 10, width of the detector threshold and timeout counters.
- DATA_W, 8, payload bits per frame (2..32).
- SYNC_VAL, 1, detected symbol value that starts a frame.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_en  in  1  controller enable; low aborts any frame and forces IDLE.
- i_smp_vld  in  1  line sample strobe, the same strobe that feeds the detector's i_vld; timeout time base.
- i_det_vld  in  1  detector output valid, one-cycle pulse per detected symbol.
- i_det_data  in  1  detector symbol value.
- i_sync_dn_th  in  CNT_W  sync window lower threshold.
- i_sync_up_th  in  CNT_W  sync window upper threshold.
- i_bit_dn_th  in  CNT_W  bit window lower threshold.
- i_bit_up_th  in  CNT_W  bit window upper threshold.
- i_tmo_th  in  CNT_W  timeout, in i_smp_vld strobes without a symbol; 0 disables timeout.
- o_dn_th  out  CNT_W  detector lower threshold, registered.
- o_up_th  out  CNT_W  detector upper threshold, registered.
- o_frm_vld  out  1  one-cycle pulse: frame complete.
- o_frm_data  out  DATA_W  received word, MSB first; held until the next o_frm_vld.
- o_frm_err  out  1  one-cycle pulse: timeout, or parity fail when the optional feature is enabled.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0 except o_dn_th=0 and o_up_th=0. The first clock after reset loads the sync thresholds.
- States: IDLE, DATA, PAR (present only with the optional feature), DONE.
- IDLE:
  - o_dn_th/o_up_th register the i_sync_* values every cycle.
  - i_en & i_det_vld & (i_det_data==SYNC_VAL) -> DATA; bit_cnt=0, tmo_cnt=0.
  - i_det_vld carrying the other value is ignored.
- DATA:
  - Thresholds register the i_bit_* values, so they are visible the cycle after entry.
  - Each i_det_vld: shift register <= {shreg[DATA_W-2:0], i_det_data}; bit_cnt++; tmo_cnt=0.
  - On the i_det_vld where bit_cnt==DATA_W-1: go to PAR if enabled, else DONE.
- PAR: the next i_det_vld is the parity bit; tmo_cnt=0; -> DONE.
- DONE (one cycle):
  - o_frm_vld=1 and o_frm_data=shreg, asserted the cycle after entering DONE.
  - Latency: 2 cycles from the final symbol's i_det_vld to the o_frm_vld edge.
  - Then -> IDLE unconditionally; thresholds revert to sync.
- Timeout (DATA/PAR only):
  - tmo_cnt increments on i_smp_vld with no i_det_vld in the same cycle; it saturates and does not wrap.
  - When tmo_cnt reaches i_tmo_th (i_tmo_th != 0): o_frm_err pulses next cycle and state -> IDLE; o_frm_vld is not asserted and o_frm_data is unchanged.
  - i_det_vld in the same cycle as the timeout hit wins: the symbol is accepted, no error.
- i_en low in any state: next state IDLE, bit_cnt/tmo_cnt cleared, no o_frm_vld, no o_frm_err.
- Symbol arriving in DONE: dropped; the controller re-hunts sync from IDLE.
- Threshold inputs changing mid-frame take effect on the next cycle, registered; no latching per frame.
- Asynchronous reset mid-frame: immediate return to reset values; the partial frame is discarded.
- bit_cnt width is clog2(DATA_W); no wrap is possible because DONE is forced at DATA_W-1.

Optional Feature:
- Macro OWT_PARITY_EN.
- Defined:
  - PAR state exists; one even-parity bit follows the payload.
  - Parity = ^shreg ^ parity_bit must be 0.
  - On mismatch, o_frm_vld and o_frm_err pulse together in the same cycle, and o_frm_data still updates.
- Undefined:
  - PAR state and parity logic are absent; DATA goes directly to DONE.
  - o_frm_err is asserted only on timeout.

Test Plan:
- Reset, then i_sync_dn_th=20, i_sync_up_th=40, i_bit_dn_th=4, i_bit_up_th=8 -> o_dn_th=20/o_up_th=40 one cycle after reset release; o_busy=0.
- Sync=1, then 8 symbols 1,0,1,0,0,1,1,0 -> thresholds 4/8 from the cycle after sync; o_frm_data=8'hA6 and o_frm_vld one pulse 2 cycles after the last symbol; thresholds back to 20/40.
- i_tmo_th=16, sync plus 3 bits, then 16 i_smp_vld strobes with no symbol -> o_frm_err pulse, o_frm_vld stays 0, state IDLE, o_frm_data unchanged.
- Sync plus 4 bits, drop i_en for 1 cycle -> IDLE; no pulses; a full later frame is received correctly.
- OWT_PARITY_EN defined, payload 8'hA6 (4 ones):
  - parity bit 0 -> o_frm_vld=1, o_frm_err=0.
  - parity bit 1 -> o_frm_vld=1 and o_frm_err=1 in the same cycle.
- Symbol of value 0 in IDLE with SYNC_VAL=1 -> ignored, o_busy stays 0; the 9th symbol arriving on the DONE cycle is dropped.
